// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Serialises the CPU's split instruction and data requests onto one shared
// single-word memory port. Each transaction ends with a one-cycle response
// pulse on the port that issued it.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   inst_read/inst_addr       instruction fetch request (held until inst_resp)
//   inst_resp/inst_rdata      fetch completion pulse and fetched word
//   data_read/data_write      load/store request (held until data_resp)
//   data_mbe/addr/wdata       store byte enables, address, store data
//   data_resp/data_rdata      load/store completion pulse and load word
//   mem_read/mem_write        memory strobes, held until mem_resp
//   mem_mbe/addr/wdata        latched byte enables, word address, write data
//   mem_resp/mem_rdata        memory completion and read data
//   err                       sticky error (illegal read+write, watchdog expiry)
//
// Parameter TIMEOUT_CYCLES bounds the memory wait; 0 disables the watchdog.
module cpu_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INST_REQ = 2'd1,
        DATA_REQ = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic        GRANT_INST = 1'b0;
    localparam logic        GRANT_DATA = 1'b1;
    localparam logic        WD_EN      = (TIMEOUT_CYCLES != 32'd0) ? 1'b1 : 1'b0;
    // Counter value on the last permitted wait cycle.
    localparam logic [31:0] WD_LAST    = WD_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

    state_t      state_r, state_nxt_s;
    logic        last_grant_r;
    logic [31:0] wd_cnt_r;

    logic        data_pend_s, grant_data_s, grant_inst_s, zero_wr_s, wd_hit_s;

    logic        inst_resp_nxt_s, data_resp_nxt_s;
    logic [31:0] inst_rdata_nxt_s, data_rdata_nxt_s;
    logic        mem_read_nxt_s, mem_write_nxt_s;
    logic [3:0]  mem_mbe_nxt_s;
    logic [31:0] mem_addr_nxt_s, mem_wdata_nxt_s;
    logic        err_nxt_s;

    // Byte offsets are dropped because the memory port is word-addressed.
    logic        unused_addr_bits_s;
    assign unused_addr_bits_s = ^{inst_addr[1:0], data_addr[1:0]};

    // On a conflict the port that did not win last time is served.
    assign data_pend_s  = data_read | data_write;
    assign grant_data_s = data_pend_s & (~inst_read | (last_grant_r == GRANT_INST));
    assign grant_inst_s = inst_read & ~grant_data_s;
    assign zero_wr_s    = data_write & (data_mbe == 4'h0);
    assign wd_hit_s     = WD_EN & (wd_cnt_r == WD_LAST);

    // State register, arbitration history and memory-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_INST;
            wd_cnt_r     <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE && grant_data_s) begin
                last_grant_r <= GRANT_DATA;
            end else if (state_r == IDLE && grant_inst_s) begin
                last_grant_r <= GRANT_INST;
            end else begin
                last_grant_r <= last_grant_r;
            end
            // Counts cycles spent waiting; restarts whenever a state is entered.
            if ((state_r == INST_REQ || state_r == DATA_REQ) && state_nxt_s == state_r) begin
                wd_cnt_r <= wd_cnt_r + 32'd1;
            end else begin
                wd_cnt_r <= 32'd0;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_data_s) begin
                    state_nxt_s = zero_wr_s ? RESP : DATA_REQ;
                end else if (grant_inst_s) begin
                    state_nxt_s = INST_REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INST_REQ, DATA_REQ: begin
                if (mem_resp || wd_hit_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        inst_resp_nxt_s  = 1'b0;
        data_resp_nxt_s  = 1'b0;
        inst_rdata_nxt_s = inst_rdata;
        data_rdata_nxt_s = data_rdata;
        mem_read_nxt_s   = mem_read;
        mem_write_nxt_s  = mem_write;
        mem_mbe_nxt_s    = mem_mbe;
        mem_addr_nxt_s   = mem_addr;
        mem_wdata_nxt_s  = mem_wdata;
        err_nxt_s        = err;
        case (state_r)
            IDLE: begin
                if (grant_data_s) begin
                    mem_addr_nxt_s = {data_addr[31:2], 2'b00};
                    if (data_write) begin
                        // Write wins over a simultaneous read; the pair is flagged.
                        mem_write_nxt_s = ~zero_wr_s;
                        mem_read_nxt_s  = 1'b0;
                        mem_mbe_nxt_s   = data_mbe;
                        mem_wdata_nxt_s = data_wdata;
                        data_resp_nxt_s = zero_wr_s;
                        err_nxt_s       = err | data_read;
                    end else begin
                        mem_read_nxt_s  = 1'b1;
                        mem_write_nxt_s = 1'b0;
                        mem_mbe_nxt_s   = 4'hF;
                    end
                end else if (grant_inst_s) begin
                    mem_addr_nxt_s  = {inst_addr[31:2], 2'b00};
                    mem_read_nxt_s  = 1'b1;
                    mem_write_nxt_s = 1'b0;
                    mem_mbe_nxt_s   = 4'hF;
                end else begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                end
            end
            INST_REQ, DATA_REQ: begin
                if (mem_resp) begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    if (state_r == INST_REQ) begin
                        inst_resp_nxt_s  = 1'b1;
                        inst_rdata_nxt_s = mem_rdata;
                    end else begin
                        data_resp_nxt_s  = 1'b1;
                        data_rdata_nxt_s = mem_write ? data_rdata : mem_rdata;
                    end
                end else if (wd_hit_s) begin
                    // Abandon the access and answer with a zero word.
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    err_nxt_s       = 1'b1;
                    if (state_r == INST_REQ) begin
                        inst_resp_nxt_s  = 1'b1;
                        inst_rdata_nxt_s = 32'd0;
                    end else begin
                        data_resp_nxt_s  = 1'b1;
                        data_rdata_nxt_s = 32'd0;
                    end
                end else begin
                    mem_read_nxt_s  = mem_read;
                    mem_write_nxt_s = mem_write;
                end
            end
            RESP: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
            end
            default: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_resp  <= 1'b0;
            data_resp  <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_mbe    <= 4'h0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            err        <= 1'b0;
        end else begin
            inst_resp  <= inst_resp_nxt_s;
            data_resp  <= data_resp_nxt_s;
            inst_rdata <= inst_rdata_nxt_s;
            data_rdata <= data_rdata_nxt_s;
            mem_read   <= mem_read_nxt_s;
            mem_write  <= mem_write_nxt_s;
            mem_mbe    <= mem_mbe_nxt_s;
            mem_addr   <= mem_addr_nxt_s;
            mem_wdata  <= mem_wdata_nxt_s;
            err        <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed testbench for cpu_mem_responder (watchdog limit 8 cycles).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cpu_mem_responder;

    logic        clk;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;

    int tests;
    int fails;

    cpu_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inst_resp"},  {31'd0, inst_resp},  32'd0);
        check({tag, "_data_resp"},  {31'd0, data_resp},  32'd0);
        check({tag, "_inst_rdata"}, inst_rdata,          32'd0);
        check({tag, "_data_rdata"}, data_rdata,          32'd0);
        check({tag, "_mem_read"},   {31'd0, mem_read},   32'd0);
        check({tag, "_mem_write"},  {31'd0, mem_write},  32'd0);
        check({tag, "_mem_mbe"},    {28'd0, mem_mbe},    32'd0);
        check({tag, "_mem_addr"},   mem_addr,            32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
        check({tag, "_err"},        {31'd0, err},        32'd0);
    endtask

    initial begin
        logic exp_data;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        inst_read = 1'b0; inst_addr = 32'd0;
        data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
        data_addr = 32'd0; data_wdata = 32'd0;
        mem_resp = 1'b0; mem_rdata = 32'd0;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single fetch, memory latency 2
        inst_read = 1'b1; inst_addr = 32'h0000_0060;
        tick();                                             // cycle 1
        check("fetch_mem_read", {31'd0, mem_read}, 32'd1);
        check("fetch_mem_addr", mem_addr, 32'h0000_0060);
        check("fetch_mem_mbe", {28'd0, mem_mbe}, 32'hF);
        tick();                                             // cycle 2
        check("fetch_wait_resp", {31'd0, inst_resp}, 32'd0);
        tick();                                             // cycle 3
        check("fetch_hold_read", {31'd0, mem_read}, 32'd1);
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        tick();                                             // cycle 4
        check("fetch_inst_resp", {31'd0, inst_resp}, 32'd1);
        check("fetch_inst_rdata", inst_rdata, 32'h0000_0013);
        check("fetch_no_data_resp", {31'd0, data_resp}, 32'd0);
        check("fetch_strobe_drop", {31'd0, mem_read}, 32'd0);
        inst_read = 1'b0; mem_resp = 1'b0;
        tick();                                             // cycle 5
        check("fetch_one_pulse", {31'd0, inst_resp}, 32'd0);

        // Conflict and fairness from reset: data, inst, data, inst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_read = 1'b1; inst_addr = 32'h0000_0100;
        data_read = 1'b1; data_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_data = (k % 2 == 0);
            tick();
            check("arb_mem_read", {31'd0, mem_read}, 32'd1);
            check("arb_mem_addr", mem_addr, exp_data ? 32'h0000_0200 : 32'h0000_0100);
            mem_resp = 1'b1; mem_rdata = 32'hD000_0000 + 32'(k);
            tick();
            check("arb_data_resp", {31'd0, data_resp}, {31'd0, exp_data});
            check("arb_inst_resp", {31'd0, inst_resp}, {31'd0, ~exp_data});
            if (exp_data) check("arb_data_rdata", data_rdata, 32'hD000_0000 + 32'(k));
            else          check("arb_inst_rdata", inst_rdata, 32'hD000_0000 + 32'(k));
            mem_resp = 1'b0;
            tick();
            check("arb_resp_clear", {30'd0, inst_resp, data_resp}, 32'd0);
        end
        inst_read = 1'b0; data_read = 1'b0;
        tick();

        // Byte store at unaligned address, latency 1
        data_write = 1'b1; data_addr = 32'h0000_1003;
        data_mbe = 4'b1000; data_wdata = 32'hAB00_0000;
        tick();
        check("st_mem_write", {31'd0, mem_write}, 32'd1);
        check("st_mem_read", {31'd0, mem_read}, 32'd0);
        check("st_mem_addr", mem_addr, 32'h0000_1000);
        check("st_mem_mbe", {28'd0, mem_mbe}, 32'h8);
        check("st_mem_wdata", mem_wdata, 32'hAB00_0000);
        tick();
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("st_data_resp", {31'd0, data_resp}, 32'd1);
        check("st_rdata_unchanged", data_rdata, 32'hD000_0002);
        check("st_strobe_drop", {31'd0, mem_write}, 32'd0);
        data_write = 1'b0; mem_resp = 1'b0;
        tick();

        // Zero-mbe write: no memory access, response at cycle 1
        data_write = 1'b1; data_mbe = 4'h0; data_addr = 32'h0000_0040;
        tick();
        check("zmbe_data_resp", {31'd0, data_resp}, 32'd1);
        check("zmbe_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check("zmbe_no_err", {31'd0, err}, 32'd0);
        data_write = 1'b0;
        tick();
        check("zmbe_one_pulse", {31'd0, data_resp}, 32'd0);

        // Read and write together: write performed, err set
        data_read = 1'b1; data_write = 1'b1; data_mbe = 4'hF;
        data_addr = 32'h0000_0044; data_wdata = 32'h1234_5678;
        tick();
        check("rw_mem_write", {31'd0, mem_write}, 32'd1);
        check("rw_mem_read", {31'd0, mem_read}, 32'd0);
        check("rw_mem_wdata", mem_wdata, 32'h1234_5678);
        check("rw_err", {31'd0, err}, 32'd1);
        mem_resp = 1'b1;
        tick();
        check("rw_data_resp", {31'd0, data_resp}, 32'd1);
        data_read = 1'b0; data_write = 1'b0; mem_resp = 1'b0;
        tick();
        check("rw_err_sticky", {31'd0, err}, 32'd1);

        // Clear err, load a nonzero word, then let a read time out
        rst = 1'b1;
        tick();
        check("rst_err_clear", {31'd0, err}, 32'd0);
        rst = 1'b0;
        data_read = 1'b1; data_addr = 32'h0000_0080;
        tick();
        mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        check("ld_data_rdata", data_rdata, 32'hCAFE_F00D);
        mem_resp = 1'b0;
        tick();
        tick();                                             // cycle 1 of timed-out read
        check("to_mem_read", {31'd0, mem_read}, 32'd1);
        for (int i = 0; i < 7; i++) tick();                 // cycle 8
        check("to_still_waiting", {31'd0, mem_read}, 32'd1);
        check("to_no_early_err", {31'd0, err}, 32'd0);
        check("to_no_early_resp", {31'd0, data_resp}, 32'd0);
        tick();                                             // cycle 9
        check("to_strobe_drop", {31'd0, mem_read}, 32'd0);
        check("to_data_resp", {31'd0, data_resp}, 32'd1);
        check("to_data_rdata", data_rdata, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        data_read = 1'b0;
        tick();

        // Reset during DATA_REQ, late mem_resp ignored, next request normal
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data_read = 1'b1; data_addr = 32'h0000_0090;
        tick();
        check("mid_mem_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0; data_read = 1'b0;
        mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        check("late_no_resp", {30'd0, inst_resp, data_resp}, 32'd0);
        check("late_rdata", data_rdata, 32'd0);
        mem_resp = 1'b0;
        tick();
        check("late_no_resp2", {30'd0, inst_resp, data_resp}, 32'd0);
        inst_read = 1'b1; inst_addr = 32'h0000_0066;
        tick();
        check("after_mem_addr", mem_addr, 32'h0000_0064);
        mem_resp = 1'b1; mem_rdata = 32'h0010_0093;
        tick();
        check("after_inst_resp", {31'd0, inst_resp}, 32'd1);
        check("after_inst_rdata", inst_rdata, 32'h0010_0093);
        inst_read = 1'b0; mem_resp = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Responder/arbiter on the far side of the CPU's split instruction and data ports.
- Accepts CPU inst and data requests and serialises them onto one shared single-word memory port.
- Returns responses with single-cycle resp pulses and registered read data.
- Sits between the pipelined RV32I core and main memory or a unified cache.

Parameters:
TIMEOUT_CYCLES, 0, memory-wait watchdog limit in cycles; 0 disables the watchdog.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
inst_read  input  1  CPU instruction read request, held until inst_resp
inst_addr  input  32  instruction address
inst_resp  output  1  one-cycle instruction response pulse
inst_rdata  output  32  instruction word, valid when inst_resp=1
data_read  input  1  CPU data read request, held until data_resp
data_write  input  1  CPU data write request, held until data_resp
data_mbe  input  4  data byte enables
data_addr  input  32  data address
data_wdata  input  32  write data
data_resp  output  1  one-cycle data response pulse
data_rdata  output  32  load word, valid when data_resp=1
mem_read  output  1  memory read strobe, held until mem_resp
mem_write  output  1  memory write strobe, held until mem_resp
mem_mbe  output  4  memory byte enables
mem_addr  output  32  word-aligned memory address
mem_wdata  output  32  memory write data
mem_resp  input  1  memory completion
mem_rdata  input  32  memory read data, valid with mem_resp
err  output  1  sticky error flag

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - inst_resp=0, data_resp=0, inst_rdata=0, data_rdata=0.
  - mem_read=0, mem_write=0, mem_mbe=0, mem_addr=0, mem_wdata=0.
  - err=0, state=IDLE, last_grant=INST.
- States: IDLE, INST_REQ, DATA_REQ, RESP.
- IDLE:
  - Sample requests. Data pending = data_read|data_write.
  - Only one port pending: grant it.
  - Both pending: grant the port not named in last_grant. Data therefore wins the first conflict after reset, and conflicts alternate thereafter.
  - On grant, latch the request: mem_addr = {addr[31:2],2'b00}; for data writes also latch mem_wdata=data_wdata and mem_mbe=data_mbe; for reads mem_mbe=4'hF.
  - Next state is INST_REQ or DATA_REQ; update last_grant.
  - No request: stay in IDLE.
- INST_REQ / DATA_REQ:
  - Hold mem_read or mem_write steady with latched address/data until mem_resp.
  - On mem_resp=1: latch mem_rdata into inst_rdata or data_rdata (data_rdata is unchanged on writes), drop mem strobes, go to RESP.
  - The matching *_resp is asserted during the RESP cycle.
- RESP:
  - Exactly one *_resp=1 for one cycle.
  - CPU requests are not sampled here, because the CPU still holds the completed request this cycle.
  - Always return to IDLE. *_rdata holds its value until the next completion on that port.
- Latency: request visible in IDLE at cycle 0 → mem strobe at cycle 1 → mem_resp at cycle 1+L → *_resp at cycle 2+L. Minimum is 2 cycles at L=0 (mem_resp in the first strobe cycle).
- Boundary cases:
  - data_write with data_mbe=4'h0: no memory access; go directly IDLE→RESP, data_resp pulses at cycle 1.
  - data_read and data_write both high: write is performed and err is set.
  - Request deasserted before resp: the latched transaction still completes and resp pulses. The CPU must tolerate this.
  - mem_resp while in IDLE or RESP: ignored.
- Watchdog:
  - Enabled when TIMEOUT_CYCLES>0. A counter increments each cycle spent in INST_REQ/DATA_REQ and clears on state entry.
  - When the counter reaches TIMEOUT_CYCLES: set err, drop strobes, go to RESP with rdata=0.
- Reset mid-transaction: all outputs return to reset values at the next edge. The pending memory transaction is abandoned, and a late mem_resp is ignored.
- err is cleared only by rst.

Test Plan:
- Single fetch: inst_read=1, inst_addr=0x60, memory L=2 returns 0x00000013 → mem_read at cycle 1 with mem_addr=0x60, mem_mbe=F; inst_resp=1 at cycle 4 with inst_rdata=0x13; exactly one pulse.
- Conflict and fairness: inst_read and data_read both asserted continuously from reset → data served first, then inst, then data, alternating; no port starved; resp pulses never overlap.
- Byte store: data_write=1, data_addr=0x1003, data_mbe=4'b1000, data_wdata=0xAB000000 → mem_write with mem_addr=0x1000, mem_mbe=8, mem_wdata=0xAB000000; data_resp one cycle after mem_resp; data_rdata unchanged.
- Zero mbe and illegal request:
  - data_write with mbe=0 → no mem strobe, data_resp at cycle 1.
  - data_read and data_write both high → write performed, err=1.
- Timeout: TIMEOUT_CYCLES=8, mem_resp held 0 → strobes drop after 8 wait cycles; data_resp pulses with data_rdata=0; err=1.
- Reset mid-operation: rst asserted during DATA_REQ, then mem_resp arrives → all outputs 0 the cycle after rst; late mem_resp produces no resp; the next request completes normally.
